// File: rtl/ext_pipe_pkg.sv
// Opcode encodings and helpers shared by the immediate-extension pipeline.
package ext_pipe_pkg;

    localparam int EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_OP_ZERO = 3'd0,
        EXT_OP_SIGN = 3'd1,
        EXT_OP_LUI  = 3'd2,
        EXT_OP_BR   = 3'd3,
        EXT_OP_SB   = 3'd4
    } ext_op_e;

    // Encodings above EXT_OP_SB are reserved and reported as errors.
    function automatic logic op_legal(input logic [EXT_OP_W-1:0] op);
        return op <= EXT_OP_SB;
    endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Immediate-in / extended-word-out handshake bundle for ext_pipe.
interface ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    import ext_pipe_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic [EXT_OP_W-1:0] in_op;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                out_err;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/ext_core.sv
// Immediate extender: zero/sign/LUI/branch/byte-sign modes, err on reserved op.
// Latency: combinational.
// Backpressure: none, pure function of in/op.
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int BR_SH = 2
) (
    input  logic [IN_W-1:0]     in,
    input  logic [EXT_OP_W-1:0] op,
    output logic [OUT_W-1:0]    out,
    output logic                err
);

    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] sb;
    logic [OUT_W-1:0] lui;

    always_comb begin
        zx              = '0;
        zx[IN_W-1:0]    = in;
        sx              = {OUT_W{in[IN_W-1]}};
        sx[IN_W-1:0]    = in;
        // byte-sign mode only looks at the low byte of the immediate
        sb              = {OUT_W{in[7]}};
        sb[7:0]         = in[7:0];
        lui             = '0;
        lui[OUT_W-1 -: IN_W] = in;

        out = '0;
        err = ~op_legal(op);
        case (op)
            EXT_OP_ZERO: out = zx;
            EXT_OP_SIGN: out = sx;
            EXT_OP_LUI:  out = lui;
            EXT_OP_BR:   out = sx << BR_SH;
            EXT_OP_SB:   out = sb;
            default:     out = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender with a 2-entry (main + skid) output buffer.
// Latency: 1 cycle from input transfer to out_valid; 1 result/cycle sustained.
// Backpressure: in_ready = ~skid_valid (registered), no out_ready->in_ready path.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int BR_SH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    ext_pipe_if.slave  bus
);

    logic [OUT_W-1:0] ext_dat;
    logic             ext_err;

    logic             m_vld;
    logic [OUT_W-1:0] m_dat;
    logic             m_err;
    logic             s_vld;
    logic [OUT_W-1:0] s_dat;
    logic             s_err;

    logic             in_xfer;
    logic             out_xfer;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .BR_SH (BR_SH)
    ) u_core (
        .in  (bus.in_data),
        .op  (bus.in_op),
        .out (ext_dat),
        .err (ext_err)
    );

    assign in_xfer  = bus.in_valid & ~s_vld;
    assign out_xfer = m_vld & bus.out_ready;

    assign bus.in_ready  = ~s_vld;
    assign bus.out_valid = m_vld;
    assign bus.out_data  = m_dat;
    assign bus.out_err   = m_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            m_dat <= '0;
            m_err <= 1'b0;
            s_vld <= 1'b0;
            s_dat <= '0;
            s_err <= 1'b0;
        end else if (out_xfer) begin
            // s_vld blocks input acceptance, so S->M never races a new result
            if (s_vld) begin
                m_dat <= s_dat;
                m_err <= s_err;
                s_vld <= 1'b0;
            end else if (in_xfer) begin
                m_dat <= ext_dat;
                m_err <= ext_err;
            end else begin
                m_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            if (m_vld) begin
                s_vld <= 1'b1;
                s_dat <= ext_dat;
                s_err <= ext_err;
            end else begin
                m_vld <= 1'b1;
                m_dat <= ext_dat;
                m_err <= ext_err;
            end
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed + randomized check of ext_pipe against a queue-based reference model.
module tb_ext_pipe;

    logic clk;
    logic rst_n;

    int errors  = 0;
    int checks  = 0;
    int dut_acc = 0;
    int dut_out = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } ent_t;

    ent_t q[$];

    ext_pipe_if #(.IN_W(16), .OUT_W(32)) a_if ();
    ext_pipe_if #(.IN_W(8),  .OUT_W(16)) b_if ();

    ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SH(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    ext_pipe #(.IN_W(8), .OUT_W(16), .BR_SH(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension computed with plain integer arithmetic.
    function automatic logic [63:0] ref_ext(input logic [63:0] din, input int op,
                                            input int iw, input int ow, input int sh);
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] sx;
        logic [63:0] b;
        mask = (64'd1 << ow) - 64'd1;
        d    = din & ((64'd1 << iw) - 64'd1);
        sx   = d[iw-1] ? (d | (~64'd0 << iw)) : d;
        b    = d & 64'hff;
        if (b[7]) b = b | ~64'hff;
        case (op)
            0:       return d;
            1:       return sx & mask;
            2:       return (d << (ow - iw)) & mask;
            3:       return (sx << sh) & mask;
            4:       return b & mask;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle on DUT A: check outputs, drive inputs, advance model, wait a cycle.
    task automatic cyc(input logic v, input logic [15:0] d, input logic [2:0] op, input logic r);
        ent_t e;
        logic acc;
        chk("a_out_valid", 64'(a_if.out_valid), 64'(q.size() > 0));
        chk("a_in_ready",  64'(a_if.in_ready),  64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("a_out_data", 64'(a_if.out_data), 64'(q[0].d));
            chk("a_out_err",  64'(a_if.out_err),  64'(q[0].e));
        end
        a_if.in_valid  = v;
        a_if.in_data   = d;
        a_if.in_op     = op;
        a_if.out_ready = r;
        if (v && a_if.in_ready) dut_acc++;
        if (a_if.out_valid && r) dut_out++;
        acc = v && (q.size() < 2);
        if (q.size() > 0 && r) void'(q.pop_front());
        if (acc) begin
            e.d = 32'(ref_ext(64'(d), int'(op), 16, 32, 2));
            e.e = (op > 3'd4);
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic dir(input string tag, input logic [15:0] d, input logic [2:0] op,
                       input logic [31:0] exp, input logic experr);
        cyc(1'b1, d, op, 1'b1);
        chk(tag, 64'(a_if.out_data), 64'(exp));
        chk({tag, "_err"}, 64'(a_if.out_err), 64'(experr));
    endtask

    task automatic bmode(input string tag, input logic [7:0] d, input logic [2:0] op,
                         input logic [15:0] exp);
        b_if.in_valid  = 1'b1;
        b_if.in_data   = d;
        b_if.in_op     = op;
        b_if.out_ready = 1'b1;
        @(negedge clk);
        b_if.in_valid = 1'b0;
        chk({tag, "_vld"}, 64'(b_if.out_valid), 64'd1);
        chk(tag, 64'(b_if.out_data), 64'(exp));
        chk({tag, "_err"}, 64'(b_if.out_err), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        int acc0;
        int out0;

        rst_n          = 1'b0;
        a_if.in_valid  = 1'b0;
        a_if.in_data   = '0;
        a_if.in_op     = '0;
        a_if.out_ready = 1'b0;
        b_if.in_valid  = 1'b0;
        b_if.in_data   = '0;
        b_if.in_op     = '0;
        b_if.out_ready = 1'b0;

        #1;
        chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_out_data",  64'(a_if.out_data),  64'd0);
        chk("rst_out_err",   64'(a_if.out_err),   64'd0);
        chk("rst_in_ready",  64'(a_if.in_ready),  64'd1);
        chk("rst_b_in_ready", 64'(b_if.in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode table for IN_W=16 / OUT_W=32
        dir("zero_fe34", 16'hfe34, 3'd0, 32'h0000_fe34, 1'b0);
        dir("sign_fe34", 16'hfe34, 3'd1, 32'hffff_fe34, 1'b0);
        dir("lui_fe34",  16'hfe34, 3'd2, 32'hfe34_0000, 1'b0);
        dir("br_fe34",   16'hfe34, 3'd3, 32'hffff_f8d0, 1'b0);
        dir("sb_fe34",   16'hfe34, 3'd4, 32'h0000_0034, 1'b0);
        dir("sb_ff80",   16'hff80, 3'd4, 32'hffff_ff80, 1'b0);
        dir("ill_ff80",  16'hff80, 3'd6, 32'h0000_0000, 1'b1);
        cyc(1'b0, 16'h0, 3'd0, 1'b1);

        // Streaming: 8 back-to-back with out_ready=1
        out0 = dut_out;
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 16'($urandom), 3'($urandom_range(0, 4)), 1'b1);
        cyc(1'b0, 16'h0, 3'd0, 1'b1);
        chk("stream_count", 64'(dut_out - out0), 64'd8);

        // Backpressure: 4 stalled cycles with in_valid held high
        acc0 = dut_acc;
        cyc(1'b1, 16'h1234, 3'd1, 1'b0);
        cyc(1'b1, 16'h8765, 3'd3, 1'b0);
        chk("bp_in_ready_3rd", 64'(a_if.in_ready), 64'd0);
        held = a_if.out_data;
        cyc(1'b1, 16'h5555, 3'd0, 1'b0);
        chk("bp_stable_4th", 64'(a_if.out_data), 64'(held));
        cyc(1'b1, 16'haaaa, 3'd0, 1'b0);
        chk("bp_stable_5th", 64'(a_if.out_data), 64'(held));
        chk("bp_accepted", 64'(dut_acc - acc0), 64'd2);
        cyc(1'b0, 16'h0, 3'd0, 1'b1);
        cyc(1'b0, 16'h0, 3'd0, 1'b1);
        chk("bp_in_ready_back", 64'(a_if.in_ready), 64'd1);
        chk("bp_drained", 64'(a_if.out_valid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));

        // Asynchronous reset mid-burst
        cyc(1'b1, 16'hbeef, 3'd6, 1'b0);
        cyc(1'b1, 16'hcafe, 3'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("arst_out_data",  64'(a_if.out_data),  64'd0);
        chk("arst_out_err",   64'(a_if.out_err),   64'd0);
        chk("arst_in_ready",  64'(a_if.in_ready),  64'd1);
        q.delete();
        a_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 16'h0042, 3'd1, 1'b1);
        cyc(1'b0, 16'h0, 3'd0, 1'b1);
        cyc(1'b0, 16'h0, 3'd0, 1'b1);

        // Parameter sweep on the IN_W=8 / OUT_W=16 instance
        bmode("b_sign_80", 8'h80, 3'd1, 16'hff80);
        bmode("b_lui_80",  8'h80, 3'd2, 16'h8000);
        bmode("b_br_c1",   8'hc1, 3'd3, 16'hff04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate extender for the datapath: the successor to the combinational EXT unit. It accepts an immediate and an extension opcode over a valid/ready handshake and returns the extended word one cycle later. A 2-entry skid buffer lets the decode stage stall without dropping or duplicating immediates. It supports zero, sign, LUI, branch-offset and byte-sign modes, and flags illegal opcodes.

## Interface
- `IN_W`, default 16: immediate width; legal range 8..OUT_W.
- `OUT_W`, default 32: result width.
- `BR_SH`, default 2: left shift applied in branch mode.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: reset; asynchronous, active-low.
- `in_valid  in  1`: upstream holds a valid immediate.
- `in_ready  out  1`: block can accept this cycle.
- `in_data  in  IN_W`: immediate.
- `in_op  in  3`: extension opcode.
- `out_valid  out  1`: result available.
- `out_ready  in  1`: downstream accepts the result.
- `out_data  out  OUT_W`: extended result.
- `out_err  out  1`: result came from an illegal opcode; qualified by out_valid.

## Operation
- Opcodes:
  - `EXT_OP_ZERO`=0: zero-extend to OUT_W.
  - `EXT_OP_SIGN`=1: sign-extend from bit IN_W-1.
  - `EXT_OP_LUI`=2: in_data << (OUT_W-IN_W); low bits 0.
  - `EXT_OP_BR`=3: sign-extend, then << BR_SH; bits shifted past OUT_W-1 are discarded.
  - `EXT_OP_SB`=4: sign-extend from bit 7, ignoring in_data[IN_W-1:8].
- Opcodes 5..7 are illegal: out_data = 0, out_err = 1.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Storage:
  - Main register M drives the outputs.
  - Skid register S holds at most one overflow result.
- Each edge, evaluated on pre-edge state:
  - Output transfer with S valid: M <= S, S empties.
  - Output transfer with S empty: M takes the new result if an input transfer occurs, else M empties.
  - No output transfer, M full, input transfer: result goes into S.
  - M empty, input transfer: result goes into M.
- in_ready = ~S_valid, registered. No combinational path from out_ready to in_ready.
- Results never reorder, drop or duplicate. The extension function is purely combinational on the accepted in_data/in_op.
- Reset mid-operation: both entries are invalidated; in-flight results are lost silently.

## Timing
- Reset values: out_valid=0, out_data=0, out_err=0, in_ready=1, S_valid=0.
- Latency: result appears on out_data one cycle after its input transfer.
- Throughput: 1 result/cycle while out_ready=1.
- Stalls:
  - out_ready low while M is full: one more input can be accepted (into S), after which in_ready=0.
  - in_ready returns to 1 the cycle after S drains.
- Full + simultaneous in/out (S valid): in_ready=0, so no input is accepted; M <= S.
- Stable-output rule: out_data and out_err are held stable while out_valid & ~out_ready.
- Empty: out_valid=0; out_data holds its last value (don't-care).

## Structure
- Shared macro header (existing opcode include): add EXT_OP_BR, EXT_OP_SB and EXT_OP_W=3 alongside the existing ZERO/SIGN/LUI.
- Sub-module `ext_core`: combinational, parametrised IN_W/OUT_W/BR_SH.
  - Inputs: in, op. Outputs: out, err.
  - Instantiated once, before the skid storage.
- ext_pipe contains only the M/S registers and the handshake logic.

## Test plan
- Reset with rst_n=0 mid-burst: outputs go to 0/0/0 and in_ready to 1 immediately, without waiting for a clock edge.
- Modes, IN_W=16/OUT_W=32, in_data=fe34:
  - ZERO -> 0000_fe34.
  - SIGN -> ffff_fe34.
  - LUI -> fe34_0000.
  - BR -> ffff_f8d0.
  - SB -> 0000_0034.
- Second set, in_data=ff80: SB -> ffff_ff80; op=6 -> 0, out_err=1.
- Streaming: 8 back-to-back inputs with out_ready=1 -> 8 results in order, one per cycle, first arriving 1 cycle after the first accept.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 accepted, in_ready=0 from the third cycle, out_data stable. On release, both results drain in order and in_ready returns to 1.
- Parameter sweep with IN_W=8, OUT_W=16:
  - in_data=80, SIGN -> ff80.
  - in_data=80, LUI -> 8000.
  - in_data=c1, BR -> ff04.
